// File: rtl/equiv_pkg.sv
// Shared constants and types for the equivalence-miter stimulus generator.
// Field widths, LFSR tap positions (1-indexed) and the controller state encoding.
package equiv_pkg;

    localparam int W0 = 17;
    localparam int W1 = 22;
    localparam int W2 = 21;
    localparam int W3 = 18;

    localparam int TAP0_A = 17;
    localparam int TAP0_B = 14;
    localparam int TAP1_A = 22;
    localparam int TAP1_B = 21;
    localparam int TAP2_A = 21;
    localparam int TAP2_B = 19;
    localparam int TAP3_A = 18;
    localparam int TAP3_B = 11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/equiv_lfsr.sv
// Fibonacci shift-left LFSR; feedback of two 1-indexed taps enters at bit 0.
// A zero seed would lock the register, so it is replaced by 1 on load.
module equiv_lfsr #(
    parameter int W     = 17,
    parameter int TAP_A = 17,
    parameter int TAP_B = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [W-1:0] seed_i,
    output logic [W-1:0] state_o
);

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;
    logic         fb;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        fb      = state_q[TAP_A-1] ^ state_q[TAP_B-1];
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == '0) ? W'(1) : seed_i;
        end else if (step_i) begin
            state_d = {state_q[W-2:0], fb};
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= W'(1);
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/equiv_stim_gen.sv
// Stimulus source and result collector for the two-implementation equivalence miter.
// Issues LFSR vectors over valid/ready, counts returned compares, records the first mismatch.
module equiv_stim_gen #(
    parameter int W0    = equiv_pkg::W0,
    parameter int W1    = equiv_pkg::W1,
    parameter int W2    = equiv_pkg::W2,
    parameter int W3    = equiv_pkg::W3,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_vec,
    input  logic [W0+W1+W2+W3-1:0] seed,
    output logic                   vec_vld,
    input  logic                   vec_rdy,
    output logic [W0-1:0]          wire0,
    output logic [W1-1:0]          wire1,
    output logic [W2-1:0]          wire2,
    output logic [W3-1:0]          wire3,
    input  logic                   res_vld,
    input  logic                   res_mis,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [CNT_W-1:0]       fail_idx,
    output logic [CNT_W-1:0]       issued
);

    import equiv_pkg::*;

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] num_q,      num_d;
    logic [CNT_W-1:0] issued_q,   issued_d;
    logic [CNT_W-1:0] res_cnt_q,  res_cnt_d;
    logic             fail_q,     fail_d;
    logic [CNT_W-1:0] fail_idx_q, fail_idx_d;

    logic             in_run;
    logic             start_ok;
    logic             xfer;
    logic             res_ok;
    logic [CNT_W-1:0] issued_inc;

    logic [W0-1:0] lfsr0;
    logic [W1-1:0] lfsr1;
    logic [W2-1:0] lfsr2;
    logic [W3-1:0] lfsr3;

    assign in_run     = (state_q == S_RUN);
    assign busy       = in_run || (state_q == S_WAIT);
    assign start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign xfer       = in_run && vec_rdy;
    // Results past the requested count are dropped so the counter cannot overrun num_q.
    assign res_ok     = res_vld && busy && (res_cnt_q != num_q);
    assign issued_inc = issued_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        issued_d   = issued_q;
        res_cnt_d  = res_cnt_q;
        fail_d     = fail_q;
        fail_idx_d = fail_idx_q;

        if (res_ok) begin
            res_cnt_d = res_cnt_q + 1'b1;
            if (res_mis && !fail_q) begin
                fail_d     = 1'b1;
                fail_idx_d = res_cnt_q;
            end
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    num_d      = num_vec;
                    issued_d   = '0;
                    res_cnt_d  = '0;
                    fail_d     = 1'b0;
                    fail_idx_d = '0;
                    state_d    = (num_vec == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    issued_d = issued_inc;
                    // Last vector out: skip WAIT if every result is already in, this cycle included.
                    if (issued_inc == num_q) begin
                        state_d = (res_cnt_d == num_q) ? S_DONE : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (res_cnt_d == num_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            issued_q   <= '0;
            res_cnt_q  <= '0;
            fail_q     <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            issued_q   <= issued_d;
            res_cnt_q  <= res_cnt_d;
            fail_q     <= fail_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    equiv_lfsr #(.W(W0), .TAP_A(TAP0_A), .TAP_B(TAP0_B)) u_lfsr0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (start_ok),
        .step_i  (xfer),
        .seed_i  (seed[W0-1:0]),
        .state_o (lfsr0)
    );

    equiv_lfsr #(.W(W1), .TAP_A(TAP1_A), .TAP_B(TAP1_B)) u_lfsr1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (start_ok),
        .step_i  (xfer),
        .seed_i  (seed[W0+W1-1 -: W1]),
        .state_o (lfsr1)
    );

    equiv_lfsr #(.W(W2), .TAP_A(TAP2_A), .TAP_B(TAP2_B)) u_lfsr2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (start_ok),
        .step_i  (xfer),
        .seed_i  (seed[W0+W1+W2-1 -: W2]),
        .state_o (lfsr2)
    );

    equiv_lfsr #(.W(W3), .TAP_A(TAP3_A), .TAP_B(TAP3_B)) u_lfsr3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (start_ok),
        .step_i  (xfer),
        .seed_i  (seed[W0+W1+W2+W3-1 -: W3]),
        .state_o (lfsr3)
    );

    // Vector fields read zero whenever no vector is on offer.
    assign vec_vld  = in_run;
    assign wire0    = in_run ? lfsr0 : '0;
    assign wire1    = in_run ? lfsr1 : '0;
    assign wire2    = in_run ? lfsr2 : '0;
    assign wire3    = in_run ? lfsr3 : '0;
    assign done     = (state_q == S_DONE);
    assign fail     = fail_q;
    assign fail_idx = fail_idx_q;
    assign issued   = issued_q;

endmodule

// File: doc/equiv_stim_gen.md
Name: equiv_stim_gen

Overview:
- Stimulus source and result collector for the two-implementation equivalence miter.
- Generates pseudo-random input vectors matching the miter's four input buses and offers them over a valid/ready handshake.
- Counts per-vector compare results returned by the miter and records the index of the first mismatch.
- Sits upstream of the miter, so the same vector stream drives both implementations; reports pass/fail to the test controller.

Parameters:
- W0, 17, width of wire0 output bus
- W1, 22, width of wire1 output bus
- W2, 21, width of wire2 output bus
- W3, 18, width of wire3 output bus
- CNT_W, 16, width of vector count and indices

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle run request; honoured in IDLE and DONE only
- num_vec  in  CNT_W  vectors to issue; sampled on accepted start
- seed  in  W0+W1+W2+W3  packed {s3,s2,s1,s0} LFSR seeds; sampled on accepted start
- vec_vld  out  1  vector valid
- vec_rdy  in  1  miter ready
- wire0..wire3  out  W0..W3  vector fields; wire1 and wire3 are treated as signed by the consumer, bit patterns only here
- res_vld  in  1  one compare result returned, in issue order
- res_mis  in  1  result is a mismatch (y_1 != y_2); qualified by res_vld
- busy  out  1  state is RUN or WAIT
- done  out  1  run complete, held until next accepted start
- fail  out  1  at least one mismatch seen this run
- fail_idx  out  CNT_W  index of first mismatching vector
- issued  out  CNT_W  vectors transferred this run

Behaviour:
- Reset: state IDLE; vec_vld, busy, done, fail = 0; fail_idx, issued = 0; wire0..3 = 0; LFSRs = 1.
- LFSRs: four independent Fibonacci shift-left LFSRs.
  - Feedback into bit0 is the XOR of 1-indexed taps: 17:(17,14), 22:(22,21), 21:(21,19), 18:(18,11). All are maximal length.
  - A zero seed slice loads 1 instead.
- FSM states: IDLE, RUN, WAIT, DONE.
- IDLE/DONE with start=1:
  - Load LFSRs, latch num_vec, clear issued, result count, fail and fail_idx; done drops.
  - num_vec==0: go to DONE (done=1 next cycle, fail=0).
  - Otherwise go to RUN; vec_vld=1 the next cycle.
- RUN:
  - wireN is driven directly from LFSR N state.
  - Transfer when vec_vld & vec_rdy: all LFSRs step once and issued increments.
  - While vec_rdy=0, vector and vec_vld are held stable; vec_vld never drops without a transfer.
  - On the transfer where issued reaches num_vec, vec_vld drops the next cycle and the FSM goes to WAIT.
- Result counter:
  - Counts res_vld pulses in RUN and WAIT.
  - First res_vld & res_mis sets fail=1 and fail_idx = result count at that pulse (0-based). Later mismatches do not change fail_idx.
  - The run continues after a mismatch.
- WAIT: when the result count reaches num_vec, go to DONE. A result arriving in the same cycle as the last transfer is handled, including the case where all results return within RUN.
- Ignored inputs:
  - res_vld in IDLE or DONE.
  - start in RUN or WAIT.
  - Results beyond num_vec.
- rst_n assertion mid-run returns immediately to reset values; no partial state survives.
- Counters do not wrap: num_vec ≤ 2^CNT_W − 1.

Decomposition:
- Shared package equiv_pkg holds:
  - field width constants W0..W3
  - tap constants
  - state enum
- One sub-module, equiv_lfsr, parameterised by width and tap pair, with load, step and seed inputs. It is instantiated four times.

Test Plan:
- Reset, then no start -> all outputs 0, vec_vld stays 0 for 20 cycles.
- Seed slices all 1, num_vec=4, vec_rdy=1 -> four transfers on consecutive cycles.
  - wire0 sequence 1,2,4,8.
  - res_vld returns all clear -> done=1, fail=0, issued=4.
- Same run with vec_rdy low for 3 cycles after the first transfer -> wire0 holds at 2 with vec_vld=1 throughout; sequence is unchanged afterwards.
- num_vec=5, res_mis=1 on results 2 and 4 -> fail=1, fail_idx=2, done after the 5th result.
- num_vec=0 -> done=1 the cycle after start, vec_vld never asserted.
- Zero seed on wire2 slice -> first wire2=1.
- rst_n low mid-RUN, then start again -> sequence restarts from the seed.
